// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: queued words are sent as start/data/[parity]/stop frames.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 9_600,
    parameter int BPS_CNT     = SYS_CLK_FRE / BPS,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_ODD  = 0
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_txd,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(BPS_CNT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    // Elaboration-time guards on the legal parameter space
    if (SYS_CLK_FRE <= 0 || BPS <= 0) begin : g_bad_clk
        $error("SYS_CLK_FRE and BPS must be positive");
    end
    if (BPS_CNT < 4 || BPS_CNT > 65535) begin : g_bad_bps
        $error("BPS_CNT out of range 4..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("DATA_BITS out of range 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 in 2..256");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    logic                   parity_q, parity_d;
`endif

    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic [DATA_BITS-1:0]   head;

    assign head     = mem_q[rd_ptr_q];
    assign tx_ready = (level_q < DEPTH_L);
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next frame when words are waiting
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        if (pop) begin
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = (^head) ^ ODD_BIT;
`endif
        end

        // Line value is decoded from the next state so the output stays a plain flop
        case (state_d)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_d;
`endif
            ST_STOP:   txd_d = 1'b1;
            default:   txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign uart_txd   = txd_q;
    assign tx_busy    = (state_q != ST_IDLE) || (level_q != '0);
    assign fifo_level = level_q;

endmodule
